spike_current_injector: RTL and testbench

Writer-side front end for the synaptic `decay` unit. It collects weighted spike events arriving during one simulation timestep and accumulates them per lane. At the timestep boundary it issues a single `write` pulse carrying the summed currents on `curr_in1`/`curr_in2`. The block sits between the spike-routing fabric and `decay`, and drives that block's `write`, `curr_in1` and `curr_in2` inputs directly.

---
 rtl/izh_pkg.sv | 14 +
 rtl/sat_add17.sv | 36 +++
 rtl/spike_current_injector.sv | 111 +++++++++++
 tb/tb_spike_current_injector.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/izh_pkg.sv
// Shared widths, current clamp limits and injector state encoding.
package izh_pkg;

  localparam int DATA_W = 17;

  localparam logic [DATA_W-1:0] CUR_MAX = 17'h0_FFFF;
  localparam logic [DATA_W-1:0] CUR_MIN = 17'h1_0000;

  typedef enum logic {
    ACCUM = 1'b0,
    FLUSH = 1'b1
  } inj_state_t;

endpackage

// File: rtl/sat_add17.sv
// Signed two's complement add; clamps to the signed range when INJ_SAT_EN is defined, else wraps.
// Combinational, no backpressure.
module sat_add17
  import izh_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

`ifdef INJ_SAT_EN
  localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

  logic [W:0] wide;

  assign wide = {a[W-1], a} + {b[W-1], b};

  // The extra sign bit disagreeing with the result sign means the true sum left the range.
  always_comb begin
    sum = wide[W-1:0];
    ovf = 1'b0;
    if (wide[W] != wide[W-1]) begin
      ovf = 1'b1;
      sum = wide[W] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  assign sum = a + b;
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/spike_current_injector.sv
// Accumulates weighted spike events per lane and flushes one write pulse per step (INJ_SAT_EN: saturating add).
// write one cycle after step_end; one-cycle ev_ready bubble during FLUSH, sender holds the event.
module spike_current_injector
  import izh_pkg::*;
#(
  parameter int DATA_W = izh_pkg::DATA_W,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ev_valid,
  output logic              ev_ready,
  input  logic              ev_lane,
  input  logic [DATA_W-1:0] ev_weight,
  input  logic              step_end,
  output logic              write,
  output logic [DATA_W-1:0] curr_in1,
  output logic [DATA_W-1:0] curr_in2,
  output logic [CNT_W-1:0]  ev_count,
  output logic              sat_flag
);

  inj_state_t state_q, state_d;
  logic       flush_go;
  logic       accept;

  logic [DATA_W-1:0] acc0_q, acc1_q;
  logic [DATA_W-1:0] add0_b, add1_b;
  logic [DATA_W-1:0] acc0_nxt, acc1_nxt;
  logic              ovf0, ovf1;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic              sat_q, sat_nxt;

  always_comb begin
    state_d  = state_q;
    ev_ready = 1'b0;
    flush_go = 1'b0;
    case (state_q)
      ACCUM: begin
        ev_ready = 1'b1;
        if (step_end) begin
          state_d  = FLUSH;
          flush_go = 1'b1;
        end
      end
      FLUSH: state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  assign accept = ev_valid && ev_ready;

  // Non-target lane adds zero, which can never overflow.
  assign add0_b = (accept && !ev_lane) ? ev_weight : '0;
  assign add1_b = (accept &&  ev_lane) ? ev_weight : '0;

  sat_add17 #(.W(DATA_W)) u_add0 (
    .a   (acc0_q),
    .b   (add0_b),
    .sum (acc0_nxt),
    .ovf (ovf0)
  );

  sat_add17 #(.W(DATA_W)) u_add1 (
    .a   (acc1_q),
    .b   (add1_b),
    .sum (acc1_nxt),
    .ovf (ovf1)
  );

  assign cnt_nxt = (accept && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
  assign sat_nxt = sat_q | ovf0 | ovf1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ACCUM;
      acc0_q   <= '0;
      acc1_q   <= '0;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      write    <= 1'b0;
      curr_in1 <= '0;
      curr_in2 <= '0;
      ev_count <= '0;
      sat_flag <= 1'b0;
    end else begin
      state_q <= state_d;
      if (flush_go) begin
        // Same-cycle event is already folded into the *_nxt values.
        write    <= 1'b1;
        curr_in1 <= acc0_nxt;
        curr_in2 <= acc1_nxt;
        ev_count <= cnt_nxt;
        sat_flag <= sat_nxt;
        acc0_q   <= '0;
        acc1_q   <= '0;
        cnt_q    <= '0;
        sat_q    <= 1'b0;
      end else begin
        write    <= 1'b0;
        curr_in1 <= '0;
        curr_in2 <= '0;
        acc0_q   <= acc0_nxt;
        acc1_q   <= acc1_nxt;
        cnt_q    <= cnt_nxt;
        sat_q    <= sat_nxt;
      end
    end
  end

endmodule

// File: tb/tb_spike_current_injector.sv
// Scoreboard bench for spike_current_injector: expected flushes queued at stimulus, checked on each write.
module tb_spike_current_injector;
  import izh_pkg::*;

  localparam int CNT_W = 8;

`ifdef INJ_SAT_EN
  localparam logic SAT_ON = 1'b1;
`else
  localparam logic SAT_ON = 1'b0;
`endif

  typedef struct packed {
    logic [DATA_W-1:0] c1;
    logic [DATA_W-1:0] c2;
    logic [CNT_W-1:0]  cnt;
    logic              sat;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              ev_valid;
  logic              ev_ready;
  logic              ev_lane;
  logic [DATA_W-1:0] ev_weight;
  logic              step_end;
  logic              write;
  logic [DATA_W-1:0] curr_in1;
  logic [DATA_W-1:0] curr_in2;
  logic [CNT_W-1:0]  ev_count;
  logic              sat_flag;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  logic prev_write = 1'b0;

  spike_current_injector #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_lane   (ev_lane),
    .ev_weight (ev_weight),
    .step_end  (step_end),
    .write     (write),
    .curr_in1  (curr_in1),
    .curr_in2  (curr_in2),
    .ev_count  (ev_count),
    .sat_flag  (sat_flag)
  );

  always #5 clk = ~clk;

  // Output monitor: every write pulse pops one expected flush.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_write = 1'b0;
    end else begin
      if (write) begin
        checks++;
        if (prev_write) begin
          failures++;
          $display("FAIL write_width: write high on consecutive cycles, required one cycle");
        end
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: write=1 with no flush expected");
        end else begin
          e = sb.pop_front();
          checks++;
          if (curr_in1 !== e.c1) begin
            failures++;
            $display("FAIL curr_in1: got %h required %h", curr_in1, e.c1);
          end
          checks++;
          if (curr_in2 !== e.c2) begin
            failures++;
            $display("FAIL curr_in2: got %h required %h", curr_in2, e.c2);
          end
          checks++;
          if (ev_count !== e.cnt) begin
            failures++;
            $display("FAIL ev_count: got %0d required %0d", ev_count, e.cnt);
          end
          checks++;
          if (sat_flag !== e.sat) begin
            failures++;
            $display("FAIL sat_flag: got %b required %b", sat_flag, e.sat);
          end
        end
      end else begin
        checks++;
        if (curr_in1 !== '0 || curr_in2 !== '0) begin
          failures++;
          $display("FAIL idle_curr: curr_in1=%h curr_in2=%h required 0 outside write", curr_in1, curr_in2);
        end
      end
      prev_write = write;
    end
  end

  task automatic send(input logic lane, input logic [DATA_W-1:0] w);
    bit got = 1'b0;
    @(posedge clk);
    #1;
    ev_valid  = 1'b1;
    ev_lane   = lane;
    ev_weight = w;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (ev_ready) got = 1'b1;
      @(posedge clk);
    end
    #1;
    ev_valid = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: ev_ready never 1, required acceptance within 10 cycles");
    end
  endtask

  task automatic pulse_step();
    @(posedge clk);
    #1 step_end = 1'b1;
    @(posedge clk);
    #1 step_end = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: %0d flushes outstanding, required 0", name, sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if (write !== 1'b0 || curr_in1 !== '0 || curr_in2 !== '0 || ev_count !== '0 || sat_flag !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: write=%b c1=%h c2=%h cnt=%0d sat=%b required all 0",
               write, curr_in1, curr_in2, ev_count, sat_flag);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if (ev_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: ev_ready=%b required 1", ev_ready);
    end
  endtask

  task automatic test_idle_flush();
    sb.push_back('{c1: '0, c2: '0, cnt: '0, sat: 1'b0});
    pulse_step();
    wait_drain("idle_flush");
  endtask

  task automatic test_accum();
    send(1'b0, 17'h08000);
    send(1'b1, 17'h00080);
    send(1'b1, 17'h00080);
    sb.push_back('{c1: 17'h08000, c2: 17'h00100, cnt: 8'd3, sat: 1'b0});
    pulse_step();
    wait_drain("accum");
    checks++;
    if (ev_count !== 8'd3) begin
      failures++;
      $display("FAIL ev_count_hold: got %0d required 3", ev_count);
    end
  endtask

  task automatic test_sat();
    send(1'b0, 17'h08000);
    send(1'b0, 17'h08000);
    sb.push_back('{c1: SAT_ON ? CUR_MAX : 17'h10000, c2: '0, cnt: 8'd2, sat: SAT_ON});
    pulse_step();
    wait_drain("sat");
    checks++;
    if (sat_flag !== SAT_ON) begin
      failures++;
      $display("FAIL sat_flag_hold: got %b required %b", sat_flag, SAT_ON);
    end
  endtask

  task automatic test_simultaneous();
    @(posedge clk);
    #1;
    ev_valid  = 1'b1;
    ev_lane   = 1'b1;
    ev_weight = 17'h00010;
    step_end  = 1'b1;
    sb.push_back('{c1: '0, c2: 17'h00010, cnt: 8'd1, sat: 1'b0});
    @(posedge clk);
    #1;
    step_end  = 1'b0;
    ev_weight = 17'h00020;
    @(negedge clk);
    checks++;
    if (ev_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_ready: ev_ready=%b in FLUSH required 0", ev_ready);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (ev_ready !== 1'b1) begin
      failures++;
      $display("FAIL post_flush_ready: ev_ready=%b required 1", ev_ready);
    end
    @(posedge clk);
    #1 ev_valid = 1'b0;
    wait_drain("simultaneous");
    sb.push_back('{c1: '0, c2: 17'h00020, cnt: 8'd1, sat: 1'b0});
    pulse_step();
    wait_drain("held_event");
  endtask

  task automatic test_back_to_back();
    send(1'b0, 17'h1FFFF);
    sb.push_back('{c1: 17'h1FFFF, c2: '0, cnt: 8'd1, sat: 1'b0});
    @(posedge clk);
    #1 step_end = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 step_end = 1'b0;
    wait_drain("back_to_back");
    repeat (3) @(negedge clk);
    checks++;
    if (ev_count !== 8'd1) begin
      failures++;
      $display("FAIL b2b_count: got %0d required 1 (second pulse dropped)", ev_count);
    end
  endtask

  task automatic test_reset_in_flush();
    send(1'b0, 17'h00123);
    send(1'b1, 17'h00045);
    pulse_step();
    checks++;
    if (write !== 1'b1) begin
      failures++;
      $display("FAIL flush_entry: write=%b required 1", write);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (write !== 1'b0 || curr_in1 !== '0 || curr_in2 !== '0) begin
      failures++;
      $display("FAIL rst_in_flush: write=%b c1=%h c2=%h required 0", write, curr_in1, curr_in2);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    sb.push_back('{c1: '0, c2: '0, cnt: '0, sat: 1'b0});
    pulse_step();
    wait_drain("post_reset_flush");
    // Partial sums discarded by a mid-step reset.
    send(1'b0, 17'h00300);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.push_back('{c1: '0, c2: '0, cnt: '0, sat: 1'b0});
    pulse_step();
    wait_drain("mid_step_reset");
  endtask

  initial begin
    ev_valid  = 1'b0;
    ev_lane   = 1'b0;
    ev_weight = '0;
    step_end  = 1'b0;
    test_reset();
    test_idle_flush();
    test_accum();
    test_sat();
    test_simultaneous();
    test_back_to_back();
    test_reset_in_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
